// File: rtl/onehot_encoder_seq.sv
// Sequential bitmask encoder: captures an N-bit mask, then emits the index of
// each set bit (lowest first) as one output beat per handshake, flagging the last.
module onehot_encoder_seq #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_one_hot,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_binary,
  output logic         o_last,
  output logic         o_zero
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] mask_rest;
  logic [W-1:0] low_idx;

  // Clearing the lowest set bit; an empty remainder means this beat is the last.
  assign mask_rest = mask_q & (mask_q - N'(1));

  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = W'(i);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          mask_d  = i_one_hot;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_ready) begin
          mask_d = mask_rest;
          if (mask_rest == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    o_binary = '0;
    o_last   = 1'b0;
    o_zero   = 1'b0;
    case (state_q)
      IDLE: o_ready = 1'b1;
      BUSY: begin
        o_valid  = 1'b1;
        o_binary = low_idx;
        o_last   = (mask_rest == '0);
        o_zero   = (mask_q == '0);
      end
      default: o_ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Bench for onehot_encoder_seq (N=4): directed scenarios plus random traffic,
// checked every cycle against a queue-of-indices reference model.
module tb_onehot_encoder_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] i_one_hot = '0;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [1:0] o_binary;
  logic       o_last;
  logic       o_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending beat indices of the current mask.
  int   q[$];
  logic m_busy = 1'b0;
  logic m_zero = 1'b0;

  onehot_encoder_seq #(.N(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_one_hot(i_one_hot), .o_valid(o_valid), .i_ready(i_ready),
    .o_binary(o_binary), .o_last(o_last), .o_zero(o_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, o_ready, !m_busy);
    chk({tag, ".valid"}, o_valid, m_busy);
    chk({tag, ".binary"}, o_binary, m_busy ? q[0] : 0);
    chk({tag, ".last"}, o_last, m_busy && q.size() == 1);
    chk({tag, ".zero"}, o_zero, m_busy && m_zero);
  endtask

  // Advance the model by one clock edge given the inputs presented this cycle.
  task automatic model_edge(input logic v, input logic [3:0] m, input logic r);
    if (!m_busy) begin
      if (v) begin
        q.delete();
        for (int i = 0; i < 4; i++) if (m[i]) q.push_back(i);
        m_zero = (q.size() == 0);
        if (m_zero) q.push_back(0);
        m_busy = 1'b1;
      end
    end else if (r) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_busy = 1'b0;
        m_zero = 1'b0;
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] m, input logic r);
    @(negedge i_clk);
    i_valid = v; i_one_hot = m; i_ready = r;
    #1;
    check_all(tag);
    model_edge(v, m, r);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge i_clk);
    #2;
    i_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    q.delete(); m_busy = 1'b0; m_zero = 1'b0;
    check_all(tag);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] m;
    // 1. reset visible before any clock edge
    #2;
    check_all("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // 2. one-hot round trip
    for (int b = 0; b < 4; b++) begin
      m = 4'b0001 << b;
      step("oh_in", 1'b1, m, 1'b1);
      step("oh_beat", 1'b0, 4'h0, 1'b1);
    end

    // 3. multi-bit mask 1011: beats 0,1,3 then ready
    step("mb_in", 1'b1, 4'b1011, 1'b1);
    step("mb_b0", 1'b0, 4'h0, 1'b1);
    step("mb_b1", 1'b0, 4'h0, 1'b1);
    step("mb_b3", 1'b0, 4'h0, 1'b1);
    step("mb_idle", 1'b0, 4'h0, 1'b1);

    // 4. back-pressure on 0110
    step("bp_in", 1'b1, 4'b0110, 1'b0);
    for (int i = 0; i < 3; i++) step("bp_stall", 1'b0, 4'h0, 1'b0);
    step("bp_b1", 1'b0, 4'h0, 1'b1);
    step("bp_b2", 1'b0, 4'h0, 1'b1);
    step("bp_idle", 1'b0, 4'h0, 1'b1);

    // 5. zero mask, then input held while busy on 1111
    step("z_in", 1'b1, 4'b0000, 1'b1);
    step("z_beat", 1'b0, 4'h0, 1'b1);
    step("blk_in", 1'b1, 4'b1111, 1'b0);
    step("blk_hold", 1'b1, 4'b0101, 1'b0);
    step("blk_hold", 1'b1, 4'b0101, 1'b1);
    step("blk_b1", 1'b1, 4'b0101, 1'b1);
    step("blk_b2", 1'b1, 4'b0101, 1'b1);
    step("blk_b3", 1'b1, 4'b0101, 1'b1);
    step("blk_cap", 1'b1, 4'b0101, 1'b1);
    step("blk_n0", 1'b0, 4'h0, 1'b1);
    step("blk_n2", 1'b0, 4'h0, 1'b1);
    step("blk_idle", 1'b0, 4'h0, 1'b1);

    // 6. reset mid-operation, then 1000
    step("rm_in", 1'b1, 4'b1111, 1'b1);
    step("rm_b0", 1'b0, 4'h0, 1'b1);
    mid_reset("rm_rst");
    step("rm_after", 1'b0, 4'h0, 1'b1);
    step("rm_in8", 1'b1, 4'b1000, 1'b1);
    step("rm_b3", 1'b0, 4'h0, 1'b1);
    step("rm_idle", 1'b0, 4'h0, 1'b1);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) mid_reset("rnd_rst");
      else step("rnd", 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_seq.md
# onehot_encoder_seq

Sequential bitmask encoder: the inverse of the team's binary-to-one-hot decoders. It accepts an N-bit mask on a valid/ready input handshake. It then emits the binary index of every set bit, lowest index first, one index per output handshake beat, and flags the final beat. It sits between request/flag vectors (interrupt lines, arbiter grants, decoder outputs) and logic that consumes indices serially.

## Interface
- `N`, default 4: mask width; must be ≥ 2.
- `W`, default $clog2(N): index width; derived, not to be overridden.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_valid`  in  1: input mask valid.
- `o_ready`  out  1: block can accept a mask.
- `i_one_hot`  in  N: mask; any bit pattern is legal, not only one-hot.
- `o_valid`  out  1: output beat valid.
- `i_ready`  in  1: downstream accepts the beat.
- `o_binary`  out  W: index of the lowest remaining set bit.
- `o_last`  out  1: current beat is the final beat for this mask.
- `o_zero`  out  1: current beat reports an all-zero mask; `o_binary` is 0.

## Operation
- The block has two states, IDLE and BUSY, plus an N-bit register `mask_q`.
- **IDLE**
  - `o_ready`=1 and `o_valid`=0.
  - On `i_valid` && `o_ready`, the block captures `i_one_hot` into `mask_q` and moves to BUSY.
  - An all-zero capture is stored as 0 and handled in BUSY.
- **BUSY**
  - `o_ready`=0 and `o_valid`=1.
  - `o_binary` = index of the lowest set bit of `mask_q`.
  - `o_last` = 1 when `mask_q` has at most one bit set.
  - `o_zero` = 1 when `mask_q` == 0; in that case `o_last`=1 and `o_binary`=0.
- **Output beat accepted** (`o_valid` && `i_ready`):
  - The block clears the lowest set bit of `mask_q`.
  - If `o_last` was 1, it returns to IDLE and `mask_q` becomes 0.
- **Stall**
  - While `o_valid`=1 and `i_ready`=0, `o_binary`, `o_last` and `o_zero` hold stable.
  - `mask_q` does not change during a stall.
- **Input while BUSY**: `i_valid` is ignored because `o_ready`=0. The upstream side must hold its mask until accepted.
- **Outputs**: `o_binary`, `o_last` and `o_zero` are combinational from `mask_q` and the state only. No input-to-output combinational path exists.
- **Beat count**: a mask with k set bits yields exactly max(k,1) beats.

## Timing
- **During reset** (`i_rst`=1):
  - State is IDLE, `mask_q`=0.
  - `o_ready`=1, `o_valid`=0, `o_binary`=0, `o_last`=0, `o_zero`=0.
  - Handshakes are ignored while `i_rst` is high.
- **Reset mid-operation**: asserting `i_rst` at any time immediately forces the reset values. The pending mask is discarded and no further beats are emitted for it.
- **Latency**: the first beat is valid in the cycle after the input transfer edge.
- **Throughput**:
  - With `i_ready` held at 1, one index is emitted per cycle.
  - The next mask can be accepted in the cycle after the last beat.
  - The input gap is therefore 1 cycle per mask; k bits cost k+1 cycles.
- **Simultaneous events**: the last-beat acceptance and a new `i_valid` in the same cycle do not transfer the input, because `o_ready`=0 in that cycle. The input transfers on the following cycle.
- **Boundary values**:
  - Mask with all N bits set: N beats with indices 0..N-1; `o_last` only on index N-1.
  - Mask with only bit N-1 set: a single beat with `o_binary`=N-1 and `o_last`=1.

## Test plan
All scenarios use N=4.
1. **Reset.** Assert `i_rst` asynchronously mid-cycle. Check `o_ready`=1, `o_valid`=0 and `o_binary`=0 immediately, without waiting for a clock edge.
2. **One-hot round trip.** Feed 4'b0001, 4'b0010, 4'b0100, 4'b1000 in turn, each with `i_ready`=1. Each mask yields one beat with `o_binary` = 0, 1, 2, 3 respectively, and `o_last`=1 on every beat.
3. **Multi-bit mask.** Feed 4'b1011 with `i_ready`=1. Expect beats 0, 1, 3 on consecutive cycles, with `o_last` only on index 3. `o_ready` returns to 1 on the following cycle.
4. **Back-pressure.** Feed 4'b0110 and hold `i_ready`=0 for 3 cycles. `o_binary`=1 holds steady with `o_last`=0. Release `i_ready` and expect beats 1 then 2, with `o_last` on 2.
5. **Zero mask and blocked input.** Feed 4'b0000: expect exactly one beat with `o_zero`=1, `o_last`=1, `o_binary`=0. While BUSY on 4'b1111, present a different mask with `i_valid`=1: it must not be captured until `o_ready`=1.
6. **Reset mid-operation.** After accepting 4'b1111 and taking one beat (index 0), pulse `i_rst`. The block returns to IDLE with no further beats. A subsequent 4'b1000 yields the single beat 3.
